// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result display.
package calc_pkg;

    localparam int RESULT_W    = 9;
    localparam int BCD_DIGITS  = 3;
    localparam int DISP_DIGITS = 4;
    localparam int BCD_W       = 4 * BCD_DIGITS;

    // Active-low gfedcba patterns for the two non-numeric glyphs
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Digit code: 0-9 are decimal digits, 10 is blank, 11 is minus
    typedef logic [3:0] digit_code_t;
    localparam digit_code_t CODE_BLANK = 4'd10;
    localparam digit_code_t CODE_MINUS = 4'd11;

    typedef enum logic {
        ST_IDLE,
        ST_CONVERT
    } state_t;

    // Two's-complement magnitude; -256 maps to 256, which still fits in 9 bits unsigned
    function automatic logic [RESULT_W-1:0] abs_mag(input logic [RESULT_W-1:0] v);
        return v[RESULT_W-1] ? (~v + RESULT_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low seven-segment pattern (gfedcba).
module seg7_decode
    import calc_pkg::*;
(
    input  digit_code_t code_i,
    output logic [6:0]  seg_o
);

    // Pure lookup; unused codes fall through to blank
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:       seg_o = 7'b1000000;
            4'd1:       seg_o = 7'b1111001;
            4'd2:       seg_o = 7'b0100100;
            4'd3:       seg_o = 7'b0110000;
            4'd4:       seg_o = 7'b0011001;
            4'd5:       seg_o = 7'b0010010;
            4'd6:       seg_o = 7'b0000010;
            4'd7:       seg_o = 7'b1111000;
            4'd8:       seg_o = 7'b0000000;
            4'd9:       seg_o = 7'b0010000;
            CODE_MINUS: seg_o = SEG_MINUS;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// Captures the signed ALU result, converts its magnitude to BCD with a
// sequential double-dabble and drives a 4-digit multiplexed display.
// Optional macro CALC_DISP_LZB_EN enables leading-zero blanking.
module calc_result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int REFRESH_W   = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RESULT_W-1:0] result_i,
    input  logic                load_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [BCD_W-1:0]    bcd_o,
    output logic                neg_o,
    output logic [3:0]          an_o,
    output logic [6:0]          seg_o
);

    state_t                state_q, state_d;
    logic [RESULT_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]      scratch_q, scratch_d;
    logic [3:0]            iter_q, iter_d;
    logic                  neg_work_q, neg_work_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic                  valid_q, valid_d;
    logic [REFRESH_W-1:0]  refresh_cnt_q, refresh_cnt_d;
    logic [1:0]            digit_idx_q, digit_idx_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic [BCD_W-1:0]      scratch_adj;
    logic [BCD_W-1:0]      scratch_shift;
    logic [RESULT_W-1:0]   mag_shift;
    logic                  last_iter;
    logic                  refresh_wrap;
    digit_code_t           digit_code;
    logic [6:0]            seg_dec;

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
        assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                      ? scratch_q[gi*4 +: 4] + 4'd3
                                      : scratch_q[gi*4 +: 4];
    end

    assign scratch_shift = {scratch_adj[BCD_W-2:0], mag_q[RESULT_W-1]};
    assign mag_shift     = {mag_q[RESULT_W-2:0], 1'b0};
    assign last_iter     = (iter_q == 4'(RESULT_W - 1));
    assign refresh_wrap  = (refresh_cnt_q == REFRESH_W'(REFRESH_DIV - 1));

    // All state registers; reset drops any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mag_q         <= '0;
            scratch_q     <= '0;
            iter_q        <= '0;
            neg_work_q    <= 1'b0;
            bcd_q         <= '0;
            neg_q         <= 1'b0;
            valid_q       <= 1'b0;
            refresh_cnt_q <= '0;
            digit_idx_q   <= '0;
            an_q          <= 4'b1110;
            seg_q         <= 7'b1000000;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            scratch_q     <= scratch_d;
            iter_q        <= iter_d;
            neg_work_q    <= neg_work_d;
            bcd_q         <= bcd_d;
            neg_q         <= neg_d;
            valid_q       <= valid_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    // Next-state: load only starts a conversion from IDLE, the 9th iteration ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (load_i)    state_d = ST_CONVERT;
            ST_CONVERT: if (last_iter) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Conversion datapath; committed value only changes on the final iteration
    always_comb begin
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        iter_d     = iter_q;
        neg_work_d = neg_work_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        valid_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (load_i) begin
                neg_work_d = result_i[RESULT_W-1];
                mag_d      = abs_mag(result_i);
                scratch_d  = '0;
                iter_d     = '0;
            end
        end else begin
            scratch_d = scratch_shift;
            mag_d     = mag_shift;
            iter_d    = iter_q + 4'd1;
            if (last_iter) begin
                bcd_d   = scratch_shift;
                neg_d   = neg_work_q && (scratch_shift != '0);
                valid_d = 1'b1;
            end
        end
    end

    // Free-running refresh; the digit enable and segments follow the next index
    always_comb begin
        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + REFRESH_W'(1);
        digit_idx_d   = refresh_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        an_d          = ~(4'(1) << digit_idx_d);
        seg_d         = seg_dec;
    end

    // Digit-select mux feeding the single decoder
    always_comb begin
        digit_code = CODE_BLANK;
        case (digit_idx_d)
            2'd0: digit_code = bcd_q[3:0];
            2'd1: begin
                digit_code = bcd_q[7:4];
`ifdef CALC_DISP_LZB_EN
                if (bcd_q[11:4] == 8'd0) digit_code = CODE_BLANK;
`endif
            end
            2'd2: begin
                digit_code = bcd_q[11:8];
`ifdef CALC_DISP_LZB_EN
                if (bcd_q[11:8] == 4'd0) digit_code = CODE_BLANK;
`endif
            end
            default: digit_code = neg_q ? CODE_MINUS : CODE_BLANK;
        endcase
    end

    seg7_decode u_seg7_decode (
        .code_i (digit_code),
        .seg_o  (seg_dec)
    );

    assign busy_o  = (state_q == ST_CONVERT);
    assign valid_o = valid_q;
    assign bcd_o   = bcd_q;
    assign neg_o   = neg_q;
    assign an_o    = an_q;
    assign seg_o   = seg_q;

endmodule
